// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the single port of a 16x8 register file among
// NUM_REQ requesters with round-robin arbitration, a valid/ready handshake
// per requester and an optional exclusive lock for atomic sequences.
// Read data returns one cycle after the transfer (synchronous register file).
// Optional build macro: REGFILE_ARB_LOCK_TIMEOUT_EN -- forces a lock release
// after LOCK_MAX consecutive locked transfers by the owner.
module regfile_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [ADDR_W-1:0]             rf_addr,
  output logic                          rf_we,
  output logic [DATA_W-1:0]             rf_wdata,
  input  logic [DATA_W-1:0]             rf_rdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX < 1) begin : g_param_check
    $error("regfile_arbiter: parameter out of range");
  end

  typedef enum logic {
    ST_FREE,
    ST_LOCKED
  } lock_state_t;

  lock_state_t         lock_st;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     scan_idx;
  logic                grant;
  logic                sel_we;
  logic                sel_lock;
  logic                hold_lock;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NUM_REQ-1:0]  rsp_vld_p1;

`ifdef REGFILE_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0]    lock_cnt;
  logic [CNT_W-1:0]    cnt_next;
`endif

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // Winner selection: only the owner while locked, else round-robin from ptr
  always_comb begin
    grant    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    if (lock_st == ST_LOCKED) begin
      grant  = req_valid[owner];
      winner = owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
        if (!grant && req_valid[scan_idx]) begin
          grant  = 1'b1;
          winner = scan_idx;
        end
      end
    end
  end

  // Grant decode and request mux toward the register file (all zero when idle)
  always_comb begin
    req_ready = '0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && winner == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        sel_we       = req_we[i];
        sel_lock     = req_lock[i];
        sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata    = req_wdata[i*DATA_W +: DATA_W];
      end
    end
    rf_we    = sel_we;
    rf_addr  = sel_addr;
    rf_wdata = sel_wdata;
    grant_id = grant ? winner : '0;
  end

  // Decide whether the lock survives the current transfer
  always_comb begin
`ifdef REGFILE_ARB_LOCK_TIMEOUT_EN
    cnt_next  = ((lock_st == ST_LOCKED) ? lock_cnt : '0) + CNT_W'(1);
    hold_lock = sel_lock && (cnt_next < CNT_W'(LOCK_MAX));
`else
    hold_lock = sel_lock;
`endif
  end

  // Lock FSM, round-robin pointer and read-response pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_st    <= ST_FREE;
      ptr        <= '0;
      owner      <= '0;
      rsp_vld_p1 <= '0;
`ifdef REGFILE_ARB_LOCK_TIMEOUT_EN
      lock_cnt   <= '0;
`endif
    end else begin
      // stage p0 -> p1: read transfer becomes a response next cycle
      rsp_vld_p1 <= req_ready & ~req_we;
      case (lock_st)
        ST_FREE: begin
          if (grant) begin
            if (hold_lock) begin
              lock_st  <= ST_LOCKED;
              owner    <= winner;
`ifdef REGFILE_ARB_LOCK_TIMEOUT_EN
              lock_cnt <= cnt_next;
`endif
            end else begin
              ptr <= next_id(winner);
            end
          end
        end
        ST_LOCKED: begin
          // Owner idle, owner drops lock, or timeout: release and move past owner
          if (!grant || !hold_lock) begin
            lock_st  <= ST_FREE;
            ptr      <= next_id(owner);
`ifdef REGFILE_ARB_LOCK_TIMEOUT_EN
            lock_cnt <= '0;
`endif
          end else begin
`ifdef REGFILE_ARB_LOCK_TIMEOUT_EN
            lock_cnt <= cnt_next;
`endif
          end
        end
        default: lock_st <= ST_FREE;
      endcase
    end
  end

  assign rsp_valid = rsp_vld_p1;
  assign rsp_rdata = rf_rdata;

endmodule
